// File: rtl/tlut_tile_accumulator.sv
//----------------------------------------------------------------------------
// tlut_tile_accumulator
//
// Purpose:
//   Sits behind the adder tree of the TLUT multiply datapath. Successive
//   DIM_A-wide partial-sum vectors (one per K-tile) are summed into a bank of
//   saturating accumulators. After NUM_TILES vectors the finished result is
//   streamed out one element per beat, with back-pressure from the consumer.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous active-high reset
//   flush      synchronous abort of any accumulation or drain in progress
//   in_valid   in_data holds a valid partial vector
//   in_ready   block accepts in_data this cycle (high only in ACCUM)
//   in_data    packed partial vector, element i at [i*ACC_WIDTH +: ACC_WIDTH]
//   out_valid  out_data holds a valid result element (high only in DRAIN)
//   out_ready  consumer accepts the current element
//   out_data   result element
//   out_idx    index of the current element
//   out_last   current element is the final one (index DIM_A-1)
//   out_sat    current element clamped during accumulation
//   busy       accumulation in progress or result draining
//   state_dbg  current FSM state (0 = ACCUM, 1 = DRAIN) for observation
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. valid is never withdrawn and the payload never changes until the
// transfer happens; ready and valid are decoded from registered state only, so
// there is no combinational path from in_valid/out_ready to any output.
//----------------------------------------------------------------------------

`ifndef DIM_A
`define DIM_A 9
`endif

`ifndef ACC_WIDTH
`define ACC_WIDTH 8
`endif

module tlut_tile_accumulator #(
   parameter int DIM_A     = `DIM_A,
   parameter int ACC_WIDTH = `ACC_WIDTH,
   parameter int OUT_WIDTH = ACC_WIDTH + 4,
   parameter int NUM_TILES = 4
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       flush,
   input  logic                                       in_valid,
   output logic                                       in_ready,
   input  logic [DIM_A*ACC_WIDTH-1:0]                 in_data,
   output logic                                       out_valid,
   input  logic                                       out_ready,
   output logic [OUT_WIDTH-1:0]                       out_data,
   output logic [(DIM_A > 1 ? $clog2(DIM_A) : 1)-1:0] out_idx,
   output logic                                       out_last,
   output logic                                       out_sat,
   output logic                                       busy,
   output logic                                       state_dbg
);

   localparam int IDX_W  = (DIM_A > 1) ? $clog2(DIM_A) : 1;
   localparam int TCNT_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;

   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DIM_A - 1);
   localparam logic [TCNT_W-1:0] LAST_TILE = TCNT_W'(NUM_TILES - 1);

   localparam logic [0:0] S_ACCUM = 1'b0;
   localparam logic [0:0] S_DRAIN = 1'b1;

   logic [0:0]           state;
   logic [TCNT_W-1:0]    tile_cnt;
   logic [IDX_W-1:0]     elem_idx;
   logic [OUT_WIDTH-1:0] acc [DIM_A];
   logic [DIM_A-1:0]     sat;

   // Per-element datapath: the incoming element is widened by one bit beyond
   // OUT_WIDTH so the carry out of the add directly flags overflow.
   logic [OUT_WIDTH:0]   in_ext  [DIM_A];
   logic [OUT_WIDTH:0]   sum     [DIM_A];
   logic [OUT_WIDTH-1:0] add_sat [DIM_A];
   logic [DIM_A-1:0]     ovf;

   logic in_fire;
   logic out_fire;

   always_comb begin
      for (int i = 0; i < DIM_A; i++) begin
         in_ext[i]  = {{(OUT_WIDTH + 1 - ACC_WIDTH){1'b0}},
                       in_data[i*ACC_WIDTH +: ACC_WIDTH]};
         sum[i]     = {1'b0, acc[i]} + in_ext[i];
         ovf[i]     = sum[i][OUT_WIDTH];
         add_sat[i] = ovf[i] ? {OUT_WIDTH{1'b1}} : sum[i][OUT_WIDTH-1:0];
      end
   end

   // Handshake decode from registered state only.
   assign in_ready  = (state == S_ACCUM);
   assign out_valid = (state == S_DRAIN);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_ACCUM;
         tile_cnt <= '0;
         elem_idx <= '0;
         sat      <= '0;
         for (int i = 0; i < DIM_A; i++) begin
            acc[i] <= '0;
         end
      end else if (flush) begin
         // Abort wins over any handshake this cycle. Accumulators are left
         // alone: the next tile-0 load overwrites them.
         state    <= S_ACCUM;
         tile_cnt <= '0;
         elem_idx <= '0;
         sat      <= '0;
      end else begin
         case (state)
            S_ACCUM: begin
               if (in_fire) begin
                  for (int i = 0; i < DIM_A; i++) begin
                     if (tile_cnt == '0) begin
                        // First tile of a result starts fresh.
                        acc[i] <= in_ext[i][OUT_WIDTH-1:0];
                        sat[i] <= 1'b0;
                     end else begin
                        acc[i] <= add_sat[i];
                        if (ovf[i]) begin
                           sat[i] <= 1'b1;
                        end
                     end
                  end
                  if (tile_cnt == LAST_TILE) begin
                     state    <= S_DRAIN;
                     tile_cnt <= '0;
                     elem_idx <= '0;
                  end else begin
                     tile_cnt <= tile_cnt + 1'b1;
                  end
               end
            end
            S_DRAIN: begin
               if (out_fire) begin
                  if (elem_idx == LAST_IDX) begin
                     elem_idx <= '0;
                     state    <= S_ACCUM;
                  end else begin
                     elem_idx <= elem_idx + 1'b1;
                  end
               end
            end
            default: begin
               state <= S_ACCUM;
            end
         endcase
      end
   end

   // Result outputs are forced to zero outside DRAIN so they read as idle
   // whenever out_valid is low, independent of stale accumulator contents.
   always_comb begin
      out_data = '0;
      out_sat  = 1'b0;
      out_last = 1'b0;
      out_idx  = '0;
      if (state == S_DRAIN) begin
         out_data = acc[elem_idx];
         out_sat  = sat[elem_idx];
         out_last = (elem_idx == LAST_IDX);
         out_idx  = elem_idx;
      end
   end

   assign busy      = (tile_cnt != '0) | (state == S_DRAIN);
   assign state_dbg = state;

endmodule

// File: tb/tb_tlut_tile_accumulator.sv
module tb_tlut_tile_accumulator;

  localparam int DIM_A     = 9;
  localparam int ACC_WIDTH = 8;
  localparam int OUT_WIDTH = 9;
  localparam int NUM_TILES = 4;
  localparam int IDX_W     = 4;
  localparam int EW        = OUT_WIDTH + IDX_W + 2;
  localparam int MAXV      = (1 << OUT_WIDTH) - 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                       flush = 1'b0;
  logic                       in_valid = 1'b0;
  logic                       in_ready;
  logic [DIM_A*ACC_WIDTH-1:0] in_data = '0;
  logic                       out_valid;
  logic                       out_ready = 1'b0;
  logic [OUT_WIDTH-1:0]       out_data;
  logic [IDX_W-1:0]           out_idx;
  logic                       out_last;
  logic                       out_sat;
  logic                       busy;
  logic                       state_dbg;

  tlut_tile_accumulator #(
    .DIM_A(DIM_A), .ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH), .NUM_TILES(NUM_TILES)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .out_sat(out_sat),
    .busy(busy), .state_dbg(state_dbg)
  );

  int pass_cnt  = 0;
  int check_cnt = 0;

  // scoreboard: {sat, last, idx, data}
  logic [EW-1:0] exp_q[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DIM_A*ACC_WIDTH-1:0] vec_ramp();
    logic [DIM_A*ACC_WIDTH-1:0] v;
    for (int i = 0; i < DIM_A; i++) v[i*ACC_WIDTH +: ACC_WIDTH] = ACC_WIDTH'(i + 1);
    return v;
  endfunction

  function automatic logic [DIM_A*ACC_WIDTH-1:0] vec_const(input int c);
    logic [DIM_A*ACC_WIDTH-1:0] v;
    for (int i = 0; i < DIM_A; i++) v[i*ACC_WIDTH +: ACC_WIDTH] = ACC_WIDTH'(c);
    return v;
  endfunction

  function automatic logic [DIM_A*ACC_WIDTH-1:0] vec_rand();
    logic [DIM_A*ACC_WIDTH-1:0] v;
    for (int i = 0; i < DIM_A; i++) v[i*ACC_WIDTH +: ACC_WIDTH] = ACC_WIDTH'($urandom_range(0, 255));
    return v;
  endfunction

  // model: same vector fed ntiles times, saturating at 2^OUT_WIDTH-1
  task automatic push_expected(input logic [DIM_A*ACC_WIDTH-1:0] d, input int ntiles);
    for (int i = 0; i < DIM_A; i++) begin
      int a;
      int e;
      bit s;
      a = 0;
      s = 1'b0;
      e = int'(d[i*ACC_WIDTH +: ACC_WIDTH]);
      for (int t = 0; t < ntiles; t++) begin
        if (t == 0) a = e;
        else begin
          a = a + e;
          if (a > MAXV) begin
            a = MAXV;
            s = 1'b1;
          end
        end
      end
      exp_q.push_back({s, (i == DIM_A - 1), IDX_W'(i), OUT_WIDTH'(a)});
    end
  endtask

  // driver: present d for ntiles accepts; completes=1 means this finishes a result
  task automatic feed(input logic [DIM_A*ACC_WIDTH-1:0] d, input int ntiles, input bit completes);
    in_data  = d;
    in_valid = 1'b1;
    for (int t = 0; t < ntiles; t++) begin
      int w;
      w = 0;
      while (!in_ready && w < 50) begin
        tick();
        w++;
      end
      check_cnt++;
      if (in_ready !== 1'b1) $display("FAIL feed_wait: in_ready=%b required 1", in_ready);
      else pass_cnt++;
      tick();
      check_cnt++;
      if (out_valid !== (completes && t == ntiles - 1))
        $display("FAIL feed_out_valid: tile %0d out_valid=%b required %b", t, out_valid,
                 (completes && t == ntiles - 1));
      else pass_cnt++;
    end
    in_valid = 1'b0;
    if (completes) push_expected(d, ntiles);
  endtask

  // monitor: mode 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random
  task automatic collect(input int mode, input int max_beats, input string tag);
    int beats;
    int cyc;
    bit stalled;
    logic [EW-1:0] obs;
    logic [EW-1:0] prev;
    logic [EW-1:0] exp;
    beats = 0;
    cyc = 0;
    stalled = 1'b0;
    prev = '0;
    while (exp_q.size() > 0 && beats < max_beats && cyc < 200) begin
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      obs = {out_sat, out_last, out_idx, out_data};
      check_cnt++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0)
        $display("FAIL %s_drain_flags: out_valid=%b in_ready=%b required 1/0", tag, out_valid, in_ready);
      else pass_cnt++;
      if (stalled) begin
        check_cnt++;
        if (obs !== prev) $display("FAIL %s_stall_stable: got %h required %h", tag, obs, prev);
        else pass_cnt++;
      end
      if (out_ready) begin
        exp = exp_q.pop_front();
        check_cnt++;
        if (obs !== exp)
          $display("FAIL %s_beat%0d: sat/last/idx/data got %b/%b/%0d/%0d required %b/%b/%0d/%0d",
                   tag, beats, obs[EW-1], obs[EW-2], obs[OUT_WIDTH +: IDX_W], obs[OUT_WIDTH-1:0],
                   exp[EW-1], exp[EW-2], exp[OUT_WIDTH +: IDX_W], exp[OUT_WIDTH-1:0]);
        else pass_cnt++;
        beats++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
      end
      prev = obs;
      cyc++;
      tick();
    end
    out_ready = 1'b0;
    if (cyc >= 200) begin
      check_cnt++;
      $display("FAIL %s_timeout: beats=%0d required %0d", tag, beats, max_beats);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_cnt++;
    if ({in_ready, out_valid, out_data, out_idx, out_last, out_sat, busy} !==
        {1'b1, 1'b0, {OUT_WIDTH{1'b0}}, {IDX_W{1'b0}}, 1'b0, 1'b0, 1'b0})
      $display("FAIL reset_values: in_ready=%b out_valid=%b data=%0d idx=%0d last=%b sat=%b busy=%b required 1 0 0 0 0 0 0",
               in_ready, out_valid, out_data, out_idx, out_last, out_sat, busy);
    else pass_cnt++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    feed(vec_ramp(), NUM_TILES, 1'b1);
    collect(0, DIM_A, "basic");
    check_cnt++;
    if (busy !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL basic_idle: busy=%b in_ready=%b required 0/1", busy, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    feed(vec_ramp(), NUM_TILES, 1'b1);
    in_valid = 1'b1;
    in_data  = vec_const(9);
    collect(1, DIM_A, "bp");
    in_valid = 1'b0;
    check_cnt++;
    if (busy !== 1'b0) $display("FAIL bp_no_accept: busy=%b required 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    logic [DIM_A*ACC_WIDTH-1:0] d;
    d = '0;
    d[ACC_WIDTH-1:0] = 8'hFF;
    feed(d, NUM_TILES, 1'b1);
    collect(0, DIM_A, "sat");
    feed(vec_const(1), NUM_TILES, 1'b1);
    collect(0, DIM_A, "sat_next");
  endtask

  task automatic test_back_to_back();
    in_data  = vec_ramp();
    in_valid = 1'b1;
    repeat (NUM_TILES) tick();
    in_data = vec_const(5);
    check_cnt++;
    if (out_valid !== 1'b1) $display("FAIL b2b_first_latency: out_valid=%b required 1", out_valid);
    else pass_cnt++;
    push_expected(vec_ramp(), NUM_TILES);
    collect(0, DIM_A, "b2b_first");
    check_cnt++;
    if (in_ready !== 1'b1) $display("FAIL b2b_ready_after_last: in_ready=%b required 1", in_ready);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (busy !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL b2b_tile0_accepted: busy=%b out_valid=%b required 1/0", busy, out_valid);
    else pass_cnt++;
    repeat (NUM_TILES - 1) tick();
    in_valid = 1'b0;
    check_cnt++;
    if (out_valid !== 1'b1) $display("FAIL b2b_second_latency: out_valid=%b required 1", out_valid);
    else pass_cnt++;
    push_expected(vec_const(5), NUM_TILES);
    collect(0, DIM_A, "b2b_second");
  endtask

  task automatic test_flush();
    feed(vec_const(7), 2, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_cnt++;
    if (busy !== 1'b0) $display("FAIL flush_accum_busy: busy=%b required 0", busy);
    else pass_cnt++;
    feed(vec_const(3), NUM_TILES, 1'b1);
    collect(0, DIM_A, "flush_sum");
    // mid-drain abort at element 4, with a handshake offered in the same cycle
    feed(vec_ramp(), NUM_TILES, 1'b1);
    collect(0, 4, "flush_pre");
    check_cnt++;
    if (out_idx !== 4'd4) $display("FAIL flush_at_idx: out_idx=%0d required 4", out_idx);
    else pass_cnt++;
    flush = 1'b1;
    out_ready = 1'b1;
    tick();
    flush = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    check_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flush_drain: out_valid=%b busy=%b in_ready=%b required 0/0/1", out_valid, busy, in_ready);
    else pass_cnt++;
    feed(vec_const(2), NUM_TILES, 1'b1);
    collect(0, DIM_A, "flush_after");
  endtask

  task automatic test_async_reset();
    feed(vec_ramp(), NUM_TILES, 1'b1);
    collect(0, 2, "arst_pre");
    rst = 1'b1;
    #2;
    check_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL arst_immediate: out_valid=%b in_ready=%b busy=%b required 0/1/0", out_valid, in_ready, busy);
    else pass_cnt++;
    rst = 1'b0;
    exp_q.delete();
    tick();
    feed(vec_const(4), NUM_TILES, 1'b1);
    collect(0, DIM_A, "arst_after");
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      feed(vec_rand(), NUM_TILES, 1'b1);
      collect(2, DIM_A, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_saturation();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    check_cnt++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_empty: %0d entries left required 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/tlut_tile_accumulator.md
# tlut_tile_accumulator

Sits directly downstream of the adder tree in the TLUT multiply datapath. It accumulates successive DIM_A-wide partial-result vectors (one per K-tile) into a saturating accumulator bank, then streams the finished vector out one element per beat over a valid/ready handshake. This turns per-tile adder-tree sums into full matrix-product results, and gives the writeback path back-pressure.

## Interface

Parameters:
- DIM_A, default `DIM_A (9): elements per result vector.
- ACC_WIDTH, default `ACC_WIDTH: width of each incoming partial sum (unsigned).
- OUT_WIDTH, default ACC_WIDTH+4: accumulator and output element width (unsigned). Must be ≥ ACC_WIDTH.
- NUM_TILES, default 4: partial vectors summed per result. Must be ≥ 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous abort; discards all accumulation and drain state.
- in_valid  in  1  in_data holds a valid partial vector.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  DIM_A*ACC_WIDTH  packed partial vector; element i sits at [i*ACC_WIDTH +: ACC_WIDTH].
- out_valid  out  1  out_data holds a valid result element.
- out_ready  in  1  consumer accepts the current element.
- out_data  out  OUT_WIDTH  result element.
- out_idx  out  $clog2(DIM_A)  index of the current element.
- out_last  out  1  current element is index DIM_A-1.
- out_sat  out  1  current element saturated during accumulation.
- busy  out  1  high when the tile count is nonzero or the block is in DRAIN.

## Operation

- The block has two states: ACCUM and DRAIN. Reset enters ACCUM with tile_cnt=0, elem_idx=0, all accumulators 0 and all sat flags 0.
- ACCUM:
  - in_ready=1 and out_valid=0.
  - An input is accepted on any cycle with in_valid & in_ready.
  - When tile_cnt==0, each acc[i] is loaded with zero-extended in_data[i] and sat[i] is cleared.
  - When tile_cnt>0, acc[i] = min(acc[i]+in_data[i], 2^OUT_WIDTH-1). sat[i] is set if clamping occurred and stays set once set.
  - Each accepted input increments tile_cnt. When the accepted input is tile NUM_TILES-1, the block moves to DRAIN with elem_idx=0 and tile_cnt=0.
- DRAIN:
  - in_ready=0 and out_valid=1.
  - out_data=acc[elem_idx], out_sat=sat[elem_idx], out_idx=elem_idx, out_last=(elem_idx==DIM_A-1).
  - On out_valid & out_ready, elem_idx increments. When the last element is taken, elem_idx returns to 0 and the block returns to ACCUM.
  - While out_ready=0, all outputs hold stable.
- flush:
  - Forces ACCUM, tile_cnt=0, elem_idx=0 and clears all sat flags. Accumulators need not be cleared; the next tile-0 load overwrites them.
  - flush has priority over any input or output handshake in the same cycle. That handshake is discarded.
- NUM_TILES=1: every accepted input moves the block directly to DRAIN with acc=in_data.

## Timing

- Reset values: in_ready=1, out_valid=0, out_data=0, out_idx=0, out_last=0, out_sat=0, busy=0.
- in_ready and out_valid are decoded from registered state only. No combinational path exists from in_valid or out_ready to any output.
- Latency: out_valid rises in the cycle after the final tile is accepted.
- A full result takes NUM_TILES accept cycles plus DIM_A drain cycles when out_ready is held high. Peak throughput is one result per NUM_TILES+DIM_A cycles.
- Cycle after the last element is taken: in_ready=1, so a new tile-0 can be accepted immediately.
- Inputs presented during DRAIN are not accepted. The upstream stage holds in_data until in_ready.
- Reset asserted mid-drain or mid-accumulation clears the state immediately, asynchronously. The partial result is lost with no output beat.

## Test plan

- Basic: NUM_TILES=4, DIM_A=9. Feed tiles with element i = i+1 in every tile. Expect 9 beats with out_data = 4*(i+1), out_idx 0..8, out_last only on beat 8, out_sat=0.
- Back-pressure: same stimulus with out_ready toggling 1,0,0,1 and in_valid held high throughout. Expect stable outputs while stalled, no dropped or duplicated beats, and in_ready=0 for the whole drain.
- Saturation: ACC_WIDTH=8, OUT_WIDTH=9. Feed element 0 = 255 for 4 tiles. Expect out_data[0]=511 with out_sat=1. Other elements fed 0 give 0 with out_sat=0. The next result, fed 1s, gives 4 with out_sat=0.
- Back-to-back: feed two results with in_valid held high. Expect the second result's tile 0 accepted in the cycle after the first result's out_last handshake, and correct sums for both.
- flush: assert flush after 2 tiles, then feed 4 tiles of value 3. Expect all beats = 12. Assert flush mid-drain at elem_idx 4; expect out_valid=0 the next cycle and busy=0.
- Async reset mid-drain: expect out_valid=0 and in_ready=1 without waiting for a clock edge, then correct operation afterwards.
